sfp_accum: RTL and testbench

SFP_ACCUM -- requirements
Module: sfp_accum

---
 rtl/sfp_accum.sv | 190 +++++++++++++++++++
 tb/tb_sfp_accum.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_accum.sv
// Special-function-processor accumulator: pops result rows from the OFIFO,
// adds the matching partial-sum row read from psum SRAM (or zero on a first
// pass), saturates each lane, optionally applies ReLU, and writes the row back.
//
// Ports
//   clk, reset         single clock; asynchronous active-low reset
//   start              launch pulse, sampled only in IDLE together with
//                      first_pass, relu_en, base_addr, num_rows
//   ofifo_valid/out    OFIFO head row; ofifo_rd pops it on this edge
//   pmem_cen/wen/a/d   psum SRAM strobes (active-low), address, write data
//   pmem_q             psum SRAM read data, valid the cycle after a read edge
//   sfp_out/sfp_valid  last result row and its one-cycle update pulse
//   busy, done         high outside IDLE; one-cycle pass-complete pulse
module sfp_accum #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned addr_w  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     first_pass,
  input  logic                     relu_en,
  input  logic [addr_w-1:0]        base_addr,
  input  logic [addr_w-1:0]        num_rows,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     pmem_cen,
  output logic                     pmem_wen,
  output logic [addr_w-1:0]        pmem_a,
  output logic [col*psum_bw-1:0]   pmem_d,
  input  logic [col*psum_bw-1:0]   pmem_q,
  output logic [col*psum_bw-1:0]   sfp_out,
  output logic                     sfp_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned ROW_W = col * psum_bw;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAITF = 3'd1,
    S_ACC   = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic              first_pass_q;
  logic              relu_q;
  logic [addr_w-1:0] base_q;
  logic [addr_w-1:0] nrows_q;
  logic [addr_w-1:0] row_q;
  logic [addr_w-1:0] row_inc;
  logic [addr_w-1:0] row_addr;
  logic [ROW_W-1:0]  fifo_q;
  logic [ROW_W-1:0]  result_q;
  logic [ROW_W-1:0]  acc_row;
  logic [psum_bw-1:0] addend;

  // Signed lane add with clamp to the psum range, then optional ReLU.
  function automatic logic [psum_bw-1:0] sat_lane(
    input logic [psum_bw-1:0] a,
    input logic [psum_bw-1:0] b,
    input logic               relu
  );
    logic [psum_bw:0]   s;
    logic [psum_bw-1:0] r;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1]) begin
      r = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    end else begin
      r = s[psum_bw-1:0];
    end
    if (relu && r[psum_bw-1]) begin
      r = '0;
    end
    return r;
  endfunction

  // Address arithmetic wraps naturally at 2^addr_w.
  assign row_addr = base_q + row_q;
  assign row_inc  = row_q + addr_w'(1);

  // Per-lane accumulate of the captured FIFO row with the SRAM read data.
  always_comb begin
    acc_row = '0;
    addend  = '0;
    for (int i = 0; i < int'(col); i++) begin
      addend = first_pass_q ? '0 : pmem_q[i*psum_bw +: psum_bw];
      acc_row[i*psum_bw +: psum_bw] = sat_lane(fifo_q[i*psum_bw +: psum_bw], addend, relu_q);
    end
  end

  // Next state and SRAM/FIFO strobes; strobes must follow ofifo_valid within
  // the same cycle so a pop is never issued against an empty FIFO.
  always_comb begin
    state_d  = state_q;
    ofifo_rd = 1'b0;
    pmem_cen = 1'b1;
    pmem_wen = 1'b1;
    pmem_a   = '0;
    pmem_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_rows == '0) ? S_DONE : S_WAITF;
        end
      end
      S_WAITF: begin
        if (ofifo_valid) begin
          ofifo_rd = 1'b1;
          pmem_cen = first_pass_q;
          pmem_a   = row_addr;
          state_d  = S_ACC;
        end
      end
      S_ACC: begin
        state_d = S_WR;
      end
      S_WR: begin
        pmem_cen = 1'b0;
        pmem_wen = 1'b0;
        pmem_a   = row_addr;
        pmem_d   = result_q;
        state_d  = (row_inc == nrows_q) ? S_DONE : S_WAITF;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register, latched config and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      first_pass_q <= 1'b0;
      relu_q       <= 1'b0;
      base_q       <= '0;
      nrows_q      <= '0;
      row_q        <= '0;
      fifo_q       <= '0;
      result_q     <= '0;
      sfp_out      <= '0;
      sfp_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q   <= state_d;
      sfp_valid <= 1'b0;
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            first_pass_q <= first_pass;
            relu_q       <= relu_en;
            base_q       <= base_addr;
            nrows_q      <= num_rows;
            row_q        <= '0;
          end
        end
        S_WAITF: begin
          if (ofifo_valid) begin
            fifo_q <= ofifo_out;
          end
        end
        S_ACC: begin
          result_q <= acc_row;
        end
        S_WR: begin
          row_q     <= row_inc;
          sfp_out   <= result_q;
          sfp_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfp_accum.sv
module tb_sfp_accum;

  localparam int unsigned COL   = 8;
  localparam int unsigned PBW   = 16;
  localparam int unsigned AW    = 11;
  localparam int unsigned ROW_W = COL * PBW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              first_pass = 1'b0;
  logic              relu_en = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW-1:0]     num_rows = '0;
  logic              ofifo_valid = 1'b0;
  logic [ROW_W-1:0]  ofifo_out = '0;
  logic              ofifo_rd;
  logic              pmem_cen;
  logic              pmem_wen;
  logic [AW-1:0]     pmem_a;
  logic [ROW_W-1:0]  pmem_d;
  logic [ROW_W-1:0]  pmem_q = '0;
  logic [ROW_W-1:0]  sfp_out;
  logic              sfp_valid;
  logic              busy;
  logic              done;

  sfp_accum #(.col(COL), .psum_bw(PBW), .addr_w(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .first_pass  (first_pass),
    .relu_en     (relu_en),
    .base_addr   (base_addr),
    .num_rows    (num_rows),
    .ofifo_valid (ofifo_valid),
    .ofifo_out   (ofifo_out),
    .ofifo_rd    (ofifo_rd),
    .pmem_cen    (pmem_cen),
    .pmem_wen    (pmem_wen),
    .pmem_a      (pmem_a),
    .pmem_d      (pmem_d),
    .pmem_q      (pmem_q),
    .sfp_out     (sfp_out),
    .sfp_valid   (sfp_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // psum SRAM model with a preload port driven by the test
  logic [ROW_W-1:0] mem [0:(1<<AW)-1];
  logic             pl_en = 1'b0;
  logic [AW-1:0]    pl_a = '0;
  logic [ROW_W-1:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!pmem_cen) begin
      if (!pmem_wen) mem[pmem_a] <= pmem_d;
      else           pmem_q <= mem[pmem_a];
    end
  end

  // bus monitor, sampled mid-cycle
  int            pop_cnt = 0, bad_pop = 0, rd_cnt = 0, bad_cen = 0, sfpv_cnt = 0, done_cnt = 0;
  logic [AW-1:0]    wr_a [$];
  logic [ROW_W-1:0] wr_d [$];
  logic [AW-1:0]    rd_a [$];

  always @(negedge clk) begin
    if (ofifo_rd) pop_cnt <= pop_cnt + 1;
    if (ofifo_rd && !ofifo_valid) bad_pop <= bad_pop + 1;
    if (!pmem_cen && pmem_wen) begin rd_cnt <= rd_cnt + 1; rd_a.push_back(pmem_a); end
    if (!pmem_cen && !pmem_wen) begin wr_a.push_back(pmem_a); wr_d.push_back(pmem_d); end
    if (!pmem_cen && !busy) bad_cen <= bad_cen + 1;
    if (sfp_valid) sfpv_cnt <= sfpv_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // check the idx-th logged write against expected address/data
  task automatic chk_wr(input string nm, input int idx, input logic [AW-1:0] ea, input logic [ROW_W-1:0] ed);
    if (idx < wr_a.size()) begin
      chk({nm, "_addr"}, ROW_W'(wr_a[idx]), ROW_W'(ea));
      chk({nm, "_data"}, wr_d[idx], ed);
    end else begin
      total++;
      bad++;
      $display("FAIL %s: write missing, got %0d writes expected index %0d", nm, wr_a.size(), idx);
    end
  endtask

  function automatic logic [ROW_W-1:0] rep(input logic [PBW-1:0] v);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(COL); i++) r[i*PBW +: PBW] = v;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [ROW_W-1:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic do_start(input logic fp, input logic relu, input logic [AW-1:0] b, input logic [AW-1:0] n);
    first_pass = fp; relu_en = relu; base_addr = b; num_rows = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // cycles counted from the start edge; done seen in cycle cyc
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", cyc);
    end
    tick();
  endtask

  typedef struct {
    logic          fp;
    logic          relu;
    logic [AW-1:0] base;
    logic [PBW-1:0] fv;
    logic [PBW-1:0] sv;
    logic [PBW-1:0] ev;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cyc, w0, r0, p0, s0, d0;

    vecs[0] = '{1'b0, 1'b0, 11'd0, 16'hFFE2, 16'd100,  16'd70};    // -30 + 100
    vecs[1] = '{1'b0, 1'b0, 11'd1, 16'd5000, 16'd30000, 16'h7FFF}; // clamp high
    vecs[2] = '{1'b0, 1'b1, 11'd2, 16'hEC78, 16'h8AD0, 16'h0000};  // clamp low then ReLU
    vecs[3] = '{1'b0, 1'b0, 11'd3, 16'hEC78, 16'h8AD0, 16'h8000};  // clamp low
    vecs[4] = '{1'b1, 1'b0, 11'd4, 16'd3,    16'd999,  16'd3};     // first pass ignores SRAM
    vecs[5] = '{1'b0, 1'b1, 11'd6, 16'd20,   16'hFFF6, 16'd10};    // ReLU keeps positive
    vecs[6] = '{1'b0, 1'b1, 11'd7, 16'hFFEC, 16'd10,   16'h0000};  // ReLU zeroes negative
    vecs[7] = '{1'b0, 1'b0, 11'd8, 16'h7FFF, 16'd1,    16'h7FFF};  // max + 1

    // reset values
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_ofifo_rd", ROW_W'(ofifo_rd), '0);
    chk("rst_cen", ROW_W'(pmem_cen), 1);
    chk("rst_wen", ROW_W'(pmem_wen), 1);
    chk("rst_a", ROW_W'(pmem_a), '0);
    chk("rst_d", pmem_d, '0);
    chk("rst_sfp_out", sfp_out, '0);
    chk("rst_sfp_valid", ROW_W'(sfp_valid), '0);
    chk("rst_busy", ROW_W'(busy), '0);
    chk("rst_done", ROW_W'(done), '0);
    reset = 1'b1;
    tick();

    // single-row table
    for (int i = 0; i < 8; i++) begin
      preload(vecs[i].base, rep(vecs[i].sv));
      ofifo_out = rep(vecs[i].fv);
      ofifo_valid = 1'b1;
      w0 = wr_a.size(); r0 = rd_cnt; s0 = sfpv_cnt;
      do_start(vecs[i].fp, vecs[i].relu, vecs[i].base, 11'd1);
      wait_done(cyc);
      ofifo_valid = 1'b0;
      chk($sformatf("vec%0d_nwr", i), ROW_W'(wr_a.size() - w0), 1);
      chk_wr($sformatf("vec%0d_wr", i), w0, vecs[i].base, rep(vecs[i].ev));
      chk($sformatf("vec%0d_sfp_out", i), sfp_out, rep(vecs[i].ev));
      chk($sformatf("vec%0d_nrd", i), ROW_W'(rd_cnt - r0), vecs[i].fp ? 0 : 1);
      chk($sformatf("vec%0d_nsfpv", i), ROW_W'(sfpv_cnt - s0), 1);
    end

    // first pass, two rows, FIFO always valid
    ofifo_out = rep(16'd3); ofifo_valid = 1'b1;
    w0 = wr_a.size(); r0 = rd_cnt; p0 = pop_cnt;
    do_start(1'b1, 1'b0, 11'd5, 11'd2);
    wait_done(cyc);
    ofifo_valid = 1'b0;
    chk("fp2_cycles", ROW_W'(cyc), 7);
    chk("fp2_nwr", ROW_W'(wr_a.size() - w0), 2);
    chk_wr("fp2_wr0", w0, 11'd5, rep(16'd3));
    chk_wr("fp2_wr1", w0 + 1, 11'd6, rep(16'd3));
    chk("fp2_nrd", ROW_W'(rd_cnt - r0), 0);
    chk("fp2_npop", ROW_W'(pop_cnt - p0), 2);

    // address wrap with a FIFO stall between rows
    preload(11'd2047, rep(16'd10));
    preload(11'd0, rep(16'd20));
    ofifo_out = rep(16'd1); ofifo_valid = 1'b1;
    w0 = wr_a.size(); r0 = rd_a.size(); p0 = pop_cnt;
    do_start(1'b0, 1'b0, 11'd2047, 11'd2);
    tick();
    ofifo_valid = 1'b0;
    repeat (4) tick();
    chk("wrap_stall_npop", ROW_W'(pop_cnt - p0), 1);
    chk("wrap_stall_busy", ROW_W'(busy), 1);
    ofifo_valid = 1'b1;
    wait_done(cyc);
    ofifo_valid = 1'b0;
    chk_wr("wrap_wr0", w0, 11'd2047, rep(16'd11));
    chk_wr("wrap_wr1", w0 + 1, 11'd0, rep(16'd21));
    chk("wrap_npop", ROW_W'(pop_cnt - p0), 2);
    chk("wrap_rd0", ROW_W'(rd_a.size() > r0 ? rd_a[r0] : 11'd1234), ROW_W'(11'd2047));
    chk("wrap_rd1", ROW_W'(rd_a.size() > r0 + 1 ? rd_a[r0+1] : 11'd1234), ROW_W'(11'd0));

    // zero rows: done only
    ofifo_valid = 1'b1;
    w0 = wr_a.size(); r0 = rd_cnt; p0 = pop_cnt; d0 = done_cnt;
    do_start(1'b0, 1'b0, 11'd3, 11'd0);
    wait_done(cyc);
    ofifo_valid = 1'b0;
    chk("zero_cycles", ROW_W'(cyc), 1);
    chk("zero_ndone", ROW_W'(done_cnt - d0), 1);
    chk("zero_nwr", ROW_W'(wr_a.size() - w0), 0);
    chk("zero_nrd", ROW_W'(rd_cnt - r0), 0);
    chk("zero_npop", ROW_W'(pop_cnt - p0), 0);
    chk("zero_done_clear", ROW_W'(done), 0);

    // start while busy is ignored
    w0 = wr_a.size(); r0 = rd_cnt; d0 = done_cnt;
    do_start(1'b1, 1'b0, 11'd20, 11'd1);
    tick();
    do_start(1'b0, 1'b1, 11'd40, 11'd3);
    tick();
    ofifo_out = rep(16'hFFF9); ofifo_valid = 1'b1;
    wait_done(cyc);
    ofifo_valid = 1'b0;
    repeat (3) tick();
    chk("busy_nwr", ROW_W'(wr_a.size() - w0), 1);
    chk_wr("busy_wr", w0, 11'd20, rep(16'hFFF9));
    chk("busy_nrd", ROW_W'(rd_cnt - r0), 0);
    chk("busy_ndone", ROW_W'(done_cnt - d0), 1);

    // reset asserted in ACC
    preload(11'd9, rep(16'd50));
    ofifo_out = rep(16'd5); ofifo_valid = 1'b1;
    w0 = wr_a.size(); d0 = done_cnt;
    do_start(1'b0, 1'b0, 11'd9, 11'd1);
    tick();
    ofifo_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("racc_ofifo_rd", ROW_W'(ofifo_rd), '0);
    chk("racc_cen", ROW_W'(pmem_cen), 1);
    chk("racc_wen", ROW_W'(pmem_wen), 1);
    chk("racc_a", ROW_W'(pmem_a), '0);
    chk("racc_d", pmem_d, '0);
    chk("racc_sfp_out", sfp_out, '0);
    chk("racc_sfp_valid", ROW_W'(sfp_valid), '0);
    chk("racc_busy", ROW_W'(busy), '0);
    chk("racc_done", ROW_W'(done), '0);
    tick(); tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("racc_nwr", ROW_W'(wr_a.size() - w0), 0);
    chk("racc_ndone", ROW_W'(done_cnt - d0), 0);

    // global protocol checks
    chk("no_pop_when_invalid", ROW_W'(bad_pop), 0);
    chk("no_cen_when_idle", ROW_W'(bad_cen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
